// File: rtl/bus_memory_if.sv
// Strobe/status bundle between a bus master and bus_memory.
// The shared 32-bit data bus stays a plain inout port on the memory so the
// tristate net is resolved at the level where all drivers meet.
interface bus_memory_if;
  logic mem_load;
  logic mem_rd;
  logic mem_wr;
  logic mem_ready;
  logic mem_fault;

  modport master (
    output mem_load,
    output mem_rd,
    output mem_wr,
    input  mem_ready,
    input  mem_fault
  );

  modport slave (
    input  mem_load,
    input  mem_rd,
    input  mem_wr,
    output mem_ready,
    output mem_fault
  );
endinterface

// File: rtl/bus_memory.sv
// Word-organised memory attached to a shared tristate bus.
// An address register (AR) is loaded from the bus; after WAIT_STATES cycles
// the block is ready and accepts a single read (combinational bus drive) or
// write (on the clock edge). Invalid addresses and protocol violations are
// reported on mem_fault; the violation flag is sticky until the next load.
module bus_memory #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst,
  inout  wire  [31:0]        bus,
  bus_memory_if.slave        mif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  typedef enum logic {
    ST_READY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic [31:0]   r_ar;
  logic          r_sticky;
  logic [31:0]   r_mem [DEPTH];

  logic          w_ar_valid;
  logic          w_is_ready;
  logic          w_access;
  logic          w_violation;
  logic          w_bus_oe;
  logic          w_wr_en;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;

  assign w_idx      = r_ar[AW+1:2];
  assign w_ar_valid = (r_ar[1:0] == 2'b00) && ({2'b00, r_ar[31:2]} < 32'(DEPTH));
  assign w_is_ready = (r_state == ST_READY);
  assign w_access   = mif.mem_rd || mif.mem_wr;

  // Any access while waiting, or rd+wr together, is a violation. A violation
  // coinciding with a load is handled in the AR register process so the
  // flag lands after the load has cleared it.
  assign w_violation = w_access && (!w_is_ready || (mif.mem_rd && mif.mem_wr));

  // Reset and load both pre-empt the data phase in the same cycle.
  assign w_bus_oe = !rst && !mif.mem_load && w_is_ready && mif.mem_rd && !mif.mem_wr;
  assign w_wr_en  = !rst && !mif.mem_load && w_is_ready && mif.mem_wr && !mif.mem_rd
                    && w_ar_valid;

  assign w_rdata = w_ar_valid ? r_mem[w_idx] : '0;
  assign bus     = w_bus_oe ? w_rdata : 'z;

  assign mif.mem_ready = w_is_ready;
  assign mif.mem_fault = !w_ar_valid || r_sticky;

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: a load restarts the wait; BUSY counts down to READY.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (mif.mem_load) begin
      w_cnt_nxt   = WS;
      w_state_nxt = (WS != 4'd0) ? ST_BUSY : ST_READY;
    end else if (r_state == ST_BUSY) begin
      if (r_cnt <= 4'd1) begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_READY;
      end else begin
        w_cnt_nxt = r_cnt - 4'd1;
      end
    end
  end

  // Address register and sticky protocol-violation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar     <= '0;
      r_sticky <= 1'b0;
    end else if (mif.mem_load) begin
      r_ar     <= bus;
      r_sticky <= w_access;
    end else if (w_violation) begin
      r_sticky <= 1'b1;
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= bus;
    end
  end

endmodule
